clock_mode_ctrl: RTL and testbench
==================================

# clock_mode_ctrl

Mode controller for the MM:SS digital clock. Takes debounced one-cycle key pulses and the 1 Hz enable, and sequences the 60-count second/minute counter pair through run and time-set modes. It drives their count enable, increment and clear inputs, and produces per-digit blanking so the digit pair being set blinks on the 7-segment display. It sits between the key-input/1 Hz blocks and the counter/decoder datapath.

## Interface
- TIMEOUT_S, 10: idle seconds in a set mode before automatic return to run mode; legal range 1..63.
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- MODEP  in  1  one-cycle pulse, mode key.
- UPP  in  1  one-cycle pulse, up key.
- CLRP  in  1  one-cycle pulse, clear key.
- EN1HZ  in  1  one-cycle pulse, once per second.
- SECEN  out  1  count enable to the seconds counter.
- SECUP  out  1  one-cycle increment to the seconds counter.
- MINUP  out  1  one-cycle increment to the minutes counter.
- CLRO  out  1  one-cycle clear to both counters.
- BLANK  out  4  per-digit blank; bit 0 is the seconds-units digit (HEX0) through bit 3, the minutes-tens digit (HEX3); 1 = segments off.
- MODE  out  2  current state: 0 RUN, 1 SET_MIN, 2 SET_SEC.

## Operation
- States:
  - RUN: clock counts; UPP ignored.
  - SET_MIN: clock stopped; UPP → MINUP.
  - SET_SEC: clock stopped; UPP → SECUP.
- Transitions on MODEP: RUN → SET_MIN → SET_SEC → RUN. Encoding value 3 is unreachable; if reached, go to RUN next cycle.
- Timeout in SET_MIN/SET_SEC:
  - Idle counter increments on EN1HZ.
  - Counter clears on entry to a set state and on any MODEP, UPP or CLRP.
  - When the counter reaches TIMEOUT_S, go to RUN and clear the counter.
  - Counter is held at 0 in RUN.
- SECEN = EN1HZ while in RUN; always 0 in set states, so no carry reaches the minutes counter while setting.
- CLRP produces CLRO in any state; the state does not change.
- Blink phase register BPH:
  - Toggles on EN1HZ in set states.
  - Forced to 0 on entry to a set state, on UPP, and in RUN.
- BLANK:
  - RUN: 4'b0000.
  - SET_MIN: {BPH,BPH,0,0}.
  - SET_SEC: {0,0,BPH,BPH}.
- Simultaneous events:
  - MODEP with UPP: the mode advances and UPP is dropped (no increment).
  - MODEP with the timeout condition: MODEP wins; the state advances normally.
  - CLRP with MODEP: CLRO is issued and the mode advances.
  - CLRP with UPP: both CLRO and the increment pulse are issued. The counter's own CLR-over-INC priority applies.
  - EN1HZ on the cycle the state leaves RUN: SECEN is still asserted, because the decision uses the pre-transition state.

## Timing
- All outputs are registered. Every response appears exactly 1 cycle after the input pulse, and every decision uses the current-cycle state.
- MODE updates 1 cycle after MODEP or timeout.
- Output pulses (SECEN, SECUP, MINUP, CLRO) are exactly 1 cycle wide, one per input pulse. Back-to-back input pulses give back-to-back output pulses.
- Timeout exit: MODE reads 0 one cycle after the EN1HZ that brings the counter to TIMEOUT_S, i.e. TIMEOUT_S seconds after the last key.
- Reset (RST low, any time, including mid-set) asynchronously forces:
  - MODE=0, SECEN=SECUP=MINUP=CLRO=0, BLANK=0.
  - Idle counter=0, BPH=0.
  - The first action after release requires a new pulse.

## Structure
- Shared package clock_pkg holds:
  - The mode encoding constants (MODE_RUN=2'd0, MODE_SET_MIN=2'd1, MODE_SET_SEC=2'd2).
  - The digit-bit index constants for BLANK.
- Sub-module clock_idle_timer holds the idle counter:
  - Inputs: CLK, RST, tick, clear, active.
  - Output: one-cycle expire pulse.
  - Parameter TIMEOUT_S; width $clog2(TIMEOUT_S+1).
- The FSM, blink register and output registers stay in clock_mode_ctrl.

## Test plan
- Reset, then 3 EN1HZ → 3 SECEN pulses, each 1 cycle after its EN1HZ; MODE=0; BLANK=0.
- MODEP → MODE=1. UPP ×2 → 2 MINUP pulses and no SECUP. EN1HZ ×3 → no SECEN; BLANK toggles 1100 / 0000 / 1100. UPP → BLANK=0000.
- MODEP ×2 from RUN → MODE=2. UPP → SECUP. MODEP → MODE=0 and SECEN resumes on the next EN1HZ.
- TIMEOUT_S=3, enter SET_MIN, no keys → MODE=0 one cycle after the 3rd EN1HZ. A repeat run with UPP after the 2nd EN1HZ → exit only after 3 further EN1HZ.
- MODEP+UPP in the same cycle in SET_MIN → MODE=2, no MINUP. CLRP+MODEP in RUN → CLRO and MODE=1. MODEP coincident with the timeout tick → MODE advances 1→2, not to 0.
- RST pulled low mid-SET_SEC with BPH=1 → all outputs 0 immediately (asynchronously). After release, EN1HZ → SECEN.

Source files
------------

// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the MM:SS clock mode controller:
//   - mode_e      : controller state encoding (also the MODE output value)
//   - BLANK_*     : bit positions of each digit within the 4-bit blank vector
//   - blank_mask  : maps a mode and blink phase to the per-digit blank vector
// ---------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_MIN = 2'd1,
    MODE_SET_SEC = 2'd2,
    MODE_ILLEGAL = 2'd3
  } mode_e;

  // Digit positions in BLANK (HEX0 .. HEX3)
  localparam int BLANK_SEC_U = 0;
  localparam int BLANK_SEC_T = 1;
  localparam int BLANK_MIN_U = 2;
  localparam int BLANK_MIN_T = 3;

  // Blank the digit pair being set while the blink phase is high.
  function automatic logic [3:0] blank_mask(input mode_e mode, input logic bph);
    logic [3:0] mask;
    mask = 4'b0000;
    case (mode)
      MODE_SET_MIN: begin
        mask[BLANK_MIN_U] = bph;
        mask[BLANK_MIN_T] = bph;
      end
      MODE_SET_SEC: begin
        mask[BLANK_SEC_U] = bph;
        mask[BLANK_SEC_T] = bph;
      end
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/clock_idle_timer.sv
// ---------------------------------------------------------------------------
// clock_idle_timer
// Counts 1 Hz ticks while a set mode is active and flags when TIMEOUT_S
// seconds pass without a key.
//   i_clk     system clock
//   i_rst_n   asynchronous active-low reset
//   i_tick    one-cycle 1 Hz enable
//   i_clear   any key pulse this cycle; restarts the count
//   i_active  high while in a set mode; count held at 0 otherwise
//   o_expire  one-cycle pulse, in the same cycle as the tick that reaches
//             TIMEOUT_S, so the controller can leave on the following edge
// ---------------------------------------------------------------------------
module clock_idle_timer
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_clear,
  input  logic i_active,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_S + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_S - 1);

  logic [CW-1:0] r_cnt;
  logic          w_expire;

  // A key in the same cycle as the final tick restarts the count instead of expiring.
  assign w_expire = i_active & i_tick & ~i_clear & (r_cnt == LAST);
  assign o_expire = w_expire;

  // Idle second counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_active || i_clear || w_expire) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// ---------------------------------------------------------------------------
// clock_mode_ctrl
// Run / set-minutes / set-seconds sequencer for the MM:SS clock.
//   i_clk     system clock
//   i_rst_n   asynchronous active-low reset
//   i_modep   mode key pulse  (RUN -> SET_MIN -> SET_SEC -> RUN)
//   i_upp     up key pulse    (increments the digit pair being set)
//   i_clrp    clear key pulse (clears both counters in any mode)
//   i_en1hz   1 Hz enable pulse
//   o_secen   seconds count enable (RUN only)
//   o_secup   seconds increment pulse (SET_SEC)
//   o_minup   minutes increment pulse (SET_MIN)
//   o_clro    clear pulse to both counters
//   o_blank   per-digit blank, bit 0 = HEX0 .. bit 3 = HEX3, 1 = off
//   o_mode    current mode (0 RUN, 1 SET_MIN, 2 SET_SEC)
// All outputs are registered; every decision uses the pre-edge state.
// ---------------------------------------------------------------------------
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_modep,
  input  logic       i_upp,
  input  logic       i_clrp,
  input  logic       i_en1hz,
  output logic       o_secen,
  output logic       o_secup,
  output logic       o_minup,
  output logic       o_clro,
  output logic [3:0] o_blank,
  output logic [1:0] o_mode
);

  mode_e      r_mode;
  logic       r_bph;
  logic       r_secen;
  logic       r_secup;
  logic       r_minup;
  logic       r_clro;
  logic [3:0] r_blank;

  mode_e      w_mode_nxt;
  logic       w_bph_nxt;
  logic       w_set_active;
  logic       w_key;
  logic       w_expire;

  assign w_set_active = (r_mode == MODE_SET_MIN) || (r_mode == MODE_SET_SEC);
  assign w_key        = i_modep | i_upp | i_clrp;

  clock_idle_timer #(
    .TIMEOUT_S (TIMEOUT_S)
  ) u_idle_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_tick   (i_en1hz),
    .i_clear  (w_key),
    .i_active (w_set_active),
    .o_expire (w_expire)
  );

  // Next mode: MODEP outranks timeout; the unused encoding falls back to RUN.
  always_comb begin
    w_mode_nxt = r_mode;
    if (i_modep) begin
      case (r_mode)
        MODE_RUN:     w_mode_nxt = MODE_SET_MIN;
        MODE_SET_MIN: w_mode_nxt = MODE_SET_SEC;
        MODE_SET_SEC: w_mode_nxt = MODE_RUN;
        default:      w_mode_nxt = MODE_RUN;
      endcase
    end else if (r_mode == MODE_ILLEGAL) begin
      w_mode_nxt = MODE_RUN;
    end else if (w_expire) begin
      w_mode_nxt = MODE_RUN;
    end else begin
      w_mode_nxt = r_mode;
    end
  end

  // Next blink phase: restarts dark-off on any mode change and on UPP so a
  // freshly incremented value is visible immediately.
  always_comb begin
    w_bph_nxt = 1'b0;
    if (w_set_active && (w_mode_nxt == r_mode)) begin
      if (i_upp) begin
        w_bph_nxt = 1'b0;
      end else if (i_en1hz) begin
        w_bph_nxt = ~r_bph;
      end else begin
        w_bph_nxt = r_bph;
      end
    end else begin
      w_bph_nxt = 1'b0;
    end
  end

  // Mode FSM, blink phase and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode  <= MODE_RUN;
      r_bph   <= 1'b0;
      r_secen <= 1'b0;
      r_secup <= 1'b0;
      r_minup <= 1'b0;
      r_clro  <= 1'b0;
      r_blank <= 4'b0000;
    end else begin
      r_mode  <= w_mode_nxt;
      r_bph   <= w_bph_nxt;
      r_secen <= i_en1hz & (r_mode == MODE_RUN);
      // A simultaneous MODEP swallows the increment.
      r_secup <= i_upp & ~i_modep & (r_mode == MODE_SET_SEC);
      r_minup <= i_upp & ~i_modep & (r_mode == MODE_SET_MIN);
      r_clro  <= i_clrp;
      r_blank <= blank_mask(w_mode_nxt, w_bph_nxt);
    end
  end

  assign o_mode  = r_mode;
  assign o_secen = r_secen;
  assign o_secup = r_secup;
  assign o_minup = r_minup;
  assign o_clro  = r_clro;
  assign o_blank = r_blank;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_mode_ctrl
// Directed self-checking bench for clock_mode_ctrl. Each step drives one
// cycle of key/tick pulses, a behavioural model pushes the expected outputs
// for the following edge onto a queue, and the entry is popped and compared
// after that edge.
// ---------------------------------------------------------------------------
module tb_clock_mode_ctrl;

  localparam int TO = 4;

  typedef struct packed {
    logic       secen;
    logic       secup;
    logic       minup;
    logic       clro;
    logic [3:0] blank;
    logic [1:0] mode;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       modep = 1'b0;
  logic       upp = 1'b0;
  logic       clrp = 1'b0;
  logic       en1hz = 1'b0;
  logic       secen;
  logic       secup;
  logic       minup;
  logic       clro;
  logic [3:0] blank;
  logic [1:0] mode;

  int vectors = 0;
  int miscompares = 0;

  exp_t q[$];

  // Reference model state
  logic [1:0] m_mode = 2'd0;
  logic       m_bph = 1'b0;
  int         m_idle = 0;

  clock_mode_ctrl #(.TIMEOUT_S(TO)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_modep (modep),
    .i_upp   (upp),
    .i_clrp  (clrp),
    .i_en1hz (en1hz),
    .o_secen (secen),
    .o_secup (secup),
    .o_minup (minup),
    .o_clro  (clro),
    .o_blank (blank),
    .o_mode  (mode)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic m, input logic u, input logic c, input logic t);
    exp_t       e;
    exp_t       got;
    logic [1:0] ns;
    logic       nb;
    logic       expire;
    @(negedge clk);
    modep = m; upp = u; clrp = c; en1hz = t;
    // Expected outputs after the next edge, from the current model state
    e.secen = t && (m_mode == 2'd0);
    e.minup = u && !m && (m_mode == 2'd1);
    e.secup = u && !m && (m_mode == 2'd2);
    e.clro  = c;
    expire  = 1'b0;
    if (m_mode == 2'd1 || m_mode == 2'd2) begin
      if (m || u || c) begin
        m_idle = 0;
      end else if (t) begin
        if (m_idle + 1 == TO) begin
          expire = 1'b1;
          m_idle = 0;
        end else begin
          m_idle = m_idle + 1;
        end
      end
    end else begin
      m_idle = 0;
    end
    if (m) ns = (m_mode == 2'd0) ? 2'd1 : (m_mode == 2'd1) ? 2'd2 : 2'd0;
    else if (expire || m_mode == 2'd3) ns = 2'd0;
    else ns = m_mode;
    if (ns == 2'd0 || ns != m_mode) nb = 1'b0;
    else if (u) nb = 1'b0;
    else if (t) nb = ~m_bph;
    else nb = m_bph;
    e.blank = (ns == 2'd1) ? {nb, nb, 2'b00} : (ns == 2'd2) ? {2'b00, nb, nb} : 4'b0000;
    e.mode  = ns;
    m_mode  = ns;
    m_bph   = nb;
    q.push_back(e);
    @(posedge clk);
    #1;
    modep = 1'b0; upp = 1'b0; clrp = 1'b0; en1hz = 1'b0;
    got = q.pop_front();
    chk("secen", {3'b000, secen}, {3'b000, got.secen});
    chk("secup", {3'b000, secup}, {3'b000, got.secup});
    chk("minup", {3'b000, minup}, {3'b000, got.minup});
    chk("clro",  {3'b000, clro},  {3'b000, got.clro});
    chk("blank", blank, got.blank);
    chk("mode",  {2'b00, mode},   {2'b00, got.mode});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mode"},  {2'b00, mode}, 4'h0);
    chk({tag, "_blank"}, blank, 4'h0);
    chk({tag, "_pulses"}, {secen, secup, minup, clro}, 4'h0);
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0);

    // RUN: three seconds, each SECEN one cycle after its EN1HZ, then back-to-back
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);                  // UPP ignored in RUN

    // SET_MIN: two back-to-back UPP, blink on ticks, UPP forces blank off
    step(1, 0, 0, 0);
    chk("enter_set_min", {2'b00, mode}, 4'h1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    chk("blink_on_1", blank, 4'b1100);
    step(0, 0, 0, 1);
    chk("blink_off", blank, 4'b0000);
    step(0, 0, 0, 1);
    chk("blink_on_2", blank, 4'b1100);
    step(0, 1, 0, 0);
    chk("blink_upp", blank, 4'b0000);

    // SET_SEC: UPP -> SECUP, then back to RUN and counting resumes
    step(1, 0, 0, 0);
    chk("enter_set_sec", {2'b00, mode}, 4'h2);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    chk("back_to_run", {2'b00, mode}, 4'h0);
    step(0, 0, 0, 1);
    chk("secen_resumes", {3'b000, secen}, 4'h1);

    // Timeout with no keys
    step(1, 0, 0, 0);
    for (int i = 0; i < TO; i++) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
    end
    chk("timeout_exit", {2'b00, mode}, 4'h0);

    // UPP after the 2nd tick restarts the idle count
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 1);
    chk("timeout_restarted", {2'b00, mode}, 4'h1);
    step(0, 0, 0, 1);
    chk("timeout_late_exit", {2'b00, mode}, 4'h0);

    // Simultaneous events
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);                  // MODEP+UPP in SET_MIN
    chk("modep_upp_mode", {2'b00, mode}, 4'h2);
    chk("modep_upp_nominup", {3'b000, minup}, 4'h0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);                  // CLRP+MODEP in RUN
    chk("clrp_modep_clro", {3'b000, clro}, 4'h1);
    chk("clrp_modep_mode", {2'b00, mode}, 4'h1);
    step(0, 1, 1, 0);                  // CLRP+UPP in SET_MIN
    chk("clrp_upp", {2'b00, clro, minup}, 4'h3);
    step(0, 0, 1, 1);                  // CLRP in set mode, tick ignored for idle
    for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 1);
    step(1, 0, 0, 1);                  // MODEP with the timeout tick
    chk("modep_beats_timeout", {2'b00, mode}, 4'h2);

    // Asynchronous reset mid-SET_SEC with the blink phase high
    step(0, 0, 0, 1);
    chk("pre_reset_blank", blank, 4'b0011);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    m_mode = 2'd0; m_bph = 1'b0; m_idle = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("post_reset_secen", {3'b000, secen}, 4'h1);
    step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
